// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Define UART_SCHED_CFG_CACHE_EN to skip the config write when it matches the last one written.
module uart_tx_sched #(
  parameter int NUM_REQ       = 4,
  parameter int TX_BUSY_BIT   = 0,
  parameter int START_TIMEOUT = 16,
  parameter int DONE_TIMEOUT  = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [9*NUM_REQ-1:0] req_cfg,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 busy,
  output logic                 ctl_reg_we,
  output logic [18:0]          ctl_reg_wdata,
  output logic [18:0]          ctl_reg_wmask,
  output logic                 st_reg_re,
  output logic [11:0]          st_reg_rmask,
  input  logic [11:0]          st_reg_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TMAX = START_TIMEOUT > DONE_TIMEOUT ? START_TIMEOUT : DONE_TIMEOUT;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [11:0] RMASK = 12'(1) << TX_BUSY_BIT;
  typedef enum logic [2:0] {IDLE, CFG_WR, DATA_WR, WAIT_START, WAIT_DONE, RELEASE} state_t;
  state_t r_state;
  logic [IW-1:0] r_ptr, r_idx, w_gnt;
  logic [7:0] r_byte, w_byte;
  logic [8:0] w_cfg;
  logic [CW-1:0] r_cnt;
  logic r_vld, w_busy, w_start, w_done, w_to, w_hit, w_unused;
  logic [NUM_REQ-1:0] r_ack;
  logic r_err, r_we, r_re;
  logic [18:0] r_wdata, r_wmask;
  logic [11:0] r_rmask;
  assign ack = r_ack;
  assign err = r_err;
  assign busy = r_state != IDLE;
  assign ctl_reg_we = r_we;
  assign ctl_reg_wdata = r_wdata;
  assign ctl_reg_wmask = r_wmask;
  assign st_reg_re = r_re;
  assign st_reg_rmask = r_rmask;
  assign w_unused = ^st_reg_rdata;
  // scan downward so the closest set bit at or after the pointer wins
  always_comb begin
    w_gnt = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[IW'((int'(r_ptr) + k) % NUM_REQ)]) w_gnt = IW'((int'(r_ptr) + k) % NUM_REQ);
  end
  assign w_byte = 8'(req_data >> (8 * int'(w_gnt)));
  assign w_cfg = 9'(req_cfg >> (9 * int'(w_gnt)));
  assign w_busy = st_reg_rdata[TX_BUSY_BIT];
  assign w_start = r_state == WAIT_START;
  // status data is only trusted once a read issued in the current wait state has returned
  assign w_done = r_vld && (w_start ? w_busy : !w_busy);
  assign w_to = !w_done && r_cnt == (w_start ? CW'(START_TIMEOUT - 1) : CW'(DONE_TIMEOUT - 1));
`ifdef UART_SCHED_CFG_CACHE_EN
  logic [8:0] r_cache;
  logic r_cvld;
  assign w_hit = r_cvld && r_cache == w_cfg;
`else
  assign w_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_idx <= '0;
      r_byte <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
      r_ack <= '0;
      r_err <= 1'b0;
      r_we <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_re <= 1'b0;
      r_rmask <= '0;
`ifdef UART_SCHED_CFG_CACHE_EN
      r_cache <= '0;
      r_cvld <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      r_we <= 1'b0;
      r_wmask <= '0;
      r_re <= 1'b0;
      r_rmask <= '0;
      case (r_state)
        IDLE: if (|req) begin
          r_idx <= w_gnt;
          r_byte <= w_byte;
          r_we <= 1'b1;
          if (w_hit) begin
            r_state <= DATA_WR;
            r_wmask <= 19'h7F801;
            r_wdata[18:11] <= w_byte;
            r_wdata[0] <= 1'b1;
          end else begin
            r_state <= CFG_WR;
            r_wmask <= 19'h007FE;
            r_wdata[10:1] <= {1'b1, w_cfg};
`ifdef UART_SCHED_CFG_CACHE_EN
            r_cache <= w_cfg;
            r_cvld <= 1'b1;
`endif
          end
        end
        CFG_WR: begin
          r_state <= DATA_WR;
          r_we <= 1'b1;
          r_wmask <= 19'h7F801;
          r_wdata[18:11] <= r_byte;
          r_wdata[0] <= 1'b1;
        end
        DATA_WR: begin
          r_state <= WAIT_START;
          r_cnt <= '0;
          r_vld <= 1'b0;
          r_re <= 1'b1;
          r_rmask <= RMASK;
        end
        WAIT_START, WAIT_DONE: begin
          r_vld <= 1'b1;
          r_re <= 1'b1;
          r_rmask <= RMASK;
          r_cnt <= r_cnt + CW'(r_cnt != '1);
          if (w_done && w_start) begin
            r_state <= WAIT_DONE;
            r_cnt <= '0;
            r_vld <= 1'b0;
          end else if (w_done || w_to) begin
            r_state <= RELEASE;
            r_re <= 1'b0;
            r_rmask <= '0;
            r_we <= 1'b1;
            r_wmask <= 19'h00001;
            r_wdata[0] <= 1'b0;
            r_ack <= NUM_REQ'(1) << r_idx;
            r_err <= w_to;
`ifdef UART_SCHED_CFG_CACHE_EN
            if (w_to) r_cvld <= 1'b0;
`endif
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_ptr <= r_idx == IW'(NUM_REQ - 1) ? '0 : r_idx + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: transaction-level model of the scheduler driven by a small UART status stub.
module tb_uart_tx_sched;
  localparam int N = 4, BB = 3, ST = 16, DT = 100;
`ifdef UART_SCHED_CFG_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [35:0] req_cfg = '0;
  logic [3:0] ack;
  logic err, busy, ctl_reg_we, st_reg_re;
  logic [18:0] ctl_reg_wdata, ctl_reg_wmask;
  logic [11:0] st_reg_rmask, st_reg_rdata;
  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .TX_BUSY_BIT(BB), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_cfg(req_cfg),
    .ack(ack), .err(err), .busy(busy), .ctl_reg_we(ctl_reg_we), .ctl_reg_wdata(ctl_reg_wdata),
    .ctl_reg_wmask(ctl_reg_wmask), .st_reg_re(st_reg_re), .st_reg_rmask(st_reg_rmask),
    .st_reg_rdata(st_reg_rdata));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // UART stub: mode 0 busy for blen cycles after activation, 1 never busy, 2 busy forever
  int mode = 0, blen = 5, bcnt = 0;
  always @(posedge clk)
    if (rst) begin
      bcnt <= 0;
      st_reg_rdata <= '0;
    end else begin
      if (ctl_reg_we && ctl_reg_wmask[0] && ctl_reg_wdata[0]) bcnt <= (mode == 1) ? 0 : blen;
      else if (bcnt > 0 && mode != 2) bcnt <= bcnt - 1;
      st_reg_rdata <= st_reg_re ? (12'hA05 | (12'(bcnt > 0) << BB)) : 12'h000;
    end

  typedef struct {logic [18:0] m; logic [18:0] v;} wr_t;
  typedef struct {logic [3:0] a; logic e;} ak_t;
  wr_t wq[$], wlog[$];
  ak_t aq[$];
  int mptr = 0;
  logic [8:0] mcache = '0;
  bit mcv = 1'b0;

  // expected register traffic for the next n grants, from the arbitration and caching rules
  task automatic predict(input int n);
    int g;
    logic [8:0] c;
    bit hit, e;
    for (int t = 0; t < n; t++) begin
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && req[2'((mptr + k) % N)]) g = (mptr + k) % N;
      if (g < 0) g = mptr;
      c = 9'(req_cfg >> (9 * g));
      hit = CACHE && mcv && c == mcache;
      e = mode != 0;
      if (!hit) wq.push_back('{19'h007FE, (19'(c) << 1) | 19'h00400});
      wq.push_back('{19'h7F801, (19'(8'(req_data >> (8 * g))) << 11) | 19'h00001});
      wq.push_back('{19'h00001, 19'h00000});
      aq.push_back('{4'(1) << g, e});
      mcache = c;
      mcv = !e;
      mptr = (g + 1) % N;
    end
  endtask

  wr_t cw;
  ak_t ca;
  always @(negedge clk)
    if (!rst) begin
      if (ctl_reg_we) begin
        wlog.push_back('{ctl_reg_wmask, ctl_reg_wdata & ctl_reg_wmask});
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got mask %0h data %0h expected no write", ctl_reg_wmask, ctl_reg_wdata);
        end else begin
          cw = wq.pop_front();
          chk("wr_mask", ctl_reg_wmask, cw.m);
          chk("wr_data", ctl_reg_wdata & ctl_reg_wmask, cw.v);
        end
      end
      if (ack != 0 || err) begin
        if (aq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack %0h err %0b expected none", ack, err);
        end else begin
          ca = aq.pop_front();
          chk("ack_vec", ack, ca.a);
          chk("ack_err", err, ca.e);
        end
      end
      if (st_reg_re) chk("rmask", st_reg_rmask, 12'(1) << BB);
      if (ctl_reg_we || st_reg_re || ack != 0) chk("busy_flag", busy, 1);
    end

  task automatic wait_ack(output int cyc, output int rec, output logic [3:0] a, output logic e);
    cyc = 0;
    rec = 0;
    a = '0;
    e = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ack != 0) begin
        a = ack;
        e = err;
        return;
      end
      if (st_reg_re) rec++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: got no ack after %0d cycles expected an ack", cyc);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_we"}, ctl_reg_we, 0);
    chk({nm, "_wdata"}, ctl_reg_wdata, 0);
    chk({nm, "_wmask"}, ctl_reg_wmask, 0);
    chk({nm, "_re"}, st_reg_re, 0);
    chk({nm, "_rmask"}, st_reg_rmask, 0);
  endtask

  int cyc, rec, ncfg;
  logic [3:0] a;
  logic e;
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    // single transfer, literal register values
    req_data[7:0] = 8'hA5;
    req_cfg[8:0] = 9'h0E3;
    wlog.delete();
    req = 4'b0001;
    predict(1);
    wait_ack(cyc, rec, a, e);
    req = 4'b0000;
    chk("s1_ack", a, 4'b0001);
    chk("s1_err", e, 0);
    @(negedge clk);
    chk("s1_nwr", wlog.size(), 3);
    chk("s1_cfg_m", wlog[0].m, 19'h007FE);
    chk("s1_cfg_v", wlog[0].v, 19'h005C6);
    chk("s1_dat_m", wlog[1].m, 19'h7F801);
    chk("s1_dat_v", wlog[1].v, 19'h52801);
    chk("s1_rel_m", wlog[2].m, 19'h00001);
    chk("s1_rel_v", wlog[2].v, 19'h00000);
    // minimum latency, same config as the previous transfer
    req_data[15:8] = 8'h3C;
    req_cfg[17:9] = 9'h0E3;
    blen = 1;
    wlog.delete();
    req = 4'b0010;
    predict(1);
    wait_ack(cyc, rec, a, e);
    req = 4'b0000;
    chk("lat", cyc, CACHE ? 6 : 7);
    chk("s2_ack", a, 4'b0010);
    @(negedge clk);
    chk("s2_nwr", wlog.size(), CACHE ? 2 : 3);
    // pointer at 2 with requesters 0 and 1 pending
    blen = 3;
    req = 4'b0011;
    predict(1);
    wait_ack(cyc, rec, a, e);
    chk("s3_first", a, 4'b0001);
    req[0] = 1'b0;
    predict(1);
    wait_ack(cyc, rec, a, e);
    chk("s3_second", a, 4'b0010);
    req = 4'b0000;
    @(negedge clk);
    // busy never rises
    req_data[23:16] = 8'h77;
    req_cfg[26:18] = 9'h155;
    mode = 1;
    req = 4'b0100;
    predict(1);
    wait_ack(cyc, rec, a, e);
    req = 4'b0000;
    chk("st_to_ack", a, 4'b0100);
    chk("st_to_err", e, 1);
    chk("st_to_polls", rec, 16);
    @(negedge clk);
    // busy stuck high, then the same config again
    req_data[31:24] = 8'h99;
    req_cfg[35:27] = 9'h0E3;
    mode = 2;
    req = 4'b1000;
    predict(1);
    wait_ack(cyc, rec, a, e);
    req = 4'b0000;
    chk("dn_to_ack", a, 4'b1000);
    chk("dn_to_err", e, 1);
    chk("dn_to_polls", rec, 102);
    @(negedge clk);
    mode = 0;
    blen = 2;
    wlog.delete();
    req = 4'b1000;
    predict(1);
    wait_ack(cyc, rec, a, e);
    req = 4'b0000;
    chk("after_to_err", e, 0);
    @(negedge clk);
    ncfg = 0;
    foreach (wlog[i]) if (wlog[i].m == 19'h007FE) ncfg++;
    chk("after_to_cfg", ncfg, 1);
    // reset while waiting for busy to fall
    mode = 2;
    req = 4'b0001;
    predict(1);
    repeat (8) @(negedge clk);
    chk("pre_rst_re", st_reg_re, 1);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    chk_zero("midrst");
    wq.delete();
    aq.delete();
    mptr = 0;
    mcv = 1'b0;
    mode = 0;
    rst = 1'b0;
    @(negedge clk);
    // all requesters held: round robin with one idle cycle between transfers
    req_cfg = {9'h1A1, 9'h0B2, 9'h155, 9'h0E3};
    blen = 2;
    req = 4'b1111;
    predict(5);
    for (int i = 0; i < 5; i++) begin
      wait_ack(cyc, rec, a, e);
      chk("rr_order", a, 4'(1) << (i % 4));
      if (i == 4) req = 4'b0000;
      @(negedge clk);
      chk("gap_idle", busy, 0);
      @(negedge clk);
      chk("gap_resume", busy, i < 4 ? 1 : 0);
    end
    repeat (2) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
